// File: rtl/depac_sum_fifo.sv
// NoC flit depacketizer for the sum function unit: destination filter, {tag, data}
// field extraction, and a DEPTH-entry FIFO with valid/ready on both sides.
module depac_sum_fifo #(
   parameter int WIDTH       = 32,
   parameter int DATA_W      = 8,
   parameter int DATA_LSB    = 0,
   parameter int TAG_W       = 2,
   parameter int TAG_LSB     = 27,
   parameter int DEST_W      = 3,
   parameter int DEST_LSB    = 29,
   parameter int MY_ID       = 0,
   parameter int CHECK_DEST  = 1,
   parameter int DEPTH       = 4,
   parameter int OUTPUTWIDTH = TAG_W + DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [OUTPUTWIDTH-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Field placement and FIFO geometry are fixed at elaboration time.
   if (DATA_LSB + DATA_W > WIDTH) begin : g_bad_data
      $error("data field does not fit in flit");
   end
   if (TAG_LSB + TAG_W > WIDTH) begin : g_bad_tag
      $error("tag field does not fit in flit");
   end
   if (DEST_LSB + DEST_W > WIDTH) begin : g_bad_dest
      $error("dest field does not fit in flit");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two, at least 2");
   end
   if (OUTPUTWIDTH != TAG_W + DATA_W) begin : g_bad_ow
      $error("OUTPUTWIDTH is derived and must not be overridden");
   end

   logic [OUTPUTWIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;
   logic [15:0]            r_drop_count;

   logic                   w_match;
   logic                   w_accept;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_pop;
   logic [OUTPUTWIDTH-1:0] w_word;
   logic                   w_unused;

   if (CHECK_DEST != 0) begin : g_dest_chk
      assign w_match = (in_data[DEST_LSB +: DEST_W] == DEST_W'(MY_ID));
   end else begin : g_dest_any
      assign w_match = 1'b1;
   end

   // Only the extracted fields are consumed; the remaining flit bits are don't-care.
   assign w_unused = ^in_data;

   assign w_word    = {in_data[TAG_LSB +: TAG_W], in_data[DATA_LSB +: DATA_W]};
   assign in_ready  = (r_count != FULL);
   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign drop_count = r_drop_count;

   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && w_match;
   assign w_drop   = w_accept && !w_match;
   assign w_pop    = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (!reset && w_push) r_mem[r_wr_ptr] <= w_word;
   end

endmodule

// File: tb/tb_depac_sum_fifo.sv
// Scoreboard bench for depac_sum_fifo: a filtering instance and a CHECK_DEST=0
// instance share stimulus; each has its own expected-output queue.
module tb_depac_sum_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready, out_valid;
   logic [9:0]  out_data;
   logic [2:0]  count;
   logic [15:0] drop_count;

   logic        in_ready_n, out_valid_n;
   logic [9:0]  out_data_n;
   logic [2:0]  count_n;
   logic [15:0] drop_count_n;

   int n_total = 0;
   int n_pass  = 0;

   logic [9:0] q_main[$];
   logic [9:0] q_nd[$];
   int         exp_drop = 0;
   bit         mon_en   = 1'b0;

   always #5 clk = ~clk;

   depac_sum_fifo u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count), .drop_count(drop_count)
   );

   depac_sum_fifo #(.CHECK_DEST(0)) u_nd (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_n),
      .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
      .count(count_n), .drop_count(drop_count_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [9:0] word(input logic [31:0] f);
      return {f[28:27], f[7:0]};
   endfunction

   function automatic logic [31:0] flit(input int i);
      return (32'(i % 4) << 27) | 32'((i + 16) & 8'hFF);
   endfunction

   // Handshakes are resolved at the negedge for the following posedge.
   always @(negedge clk) begin
      logic [9:0] e;
      bit m_full, m_empty, n_full, n_empty;
      m_full  = (q_main.size() == 4);
      m_empty = (q_main.size() == 0);
      n_full  = (q_nd.size() == 4);
      n_empty = (q_nd.size() == 0);
      if (mon_en) begin
         check("count",      32'(count),      32'(q_main.size()));
         check("in_ready",   32'(in_ready),   32'(!m_full));
         check("out_valid",  32'(out_valid),  32'(!m_empty));
         check("drop_count", 32'(drop_count), 32'(exp_drop));
         check("count_nd",   32'(count_n),    32'(q_nd.size()));
         check("drop_nd",    32'(drop_count_n), 32'(0));
      end
      if (reset) begin
         q_main.delete();
         q_nd.delete();
         exp_drop = 0;
      end else begin
         if (!m_empty && out_ready) begin
            e = q_main.pop_front();
            check("out_data", 32'(out_data), 32'(e));
         end
         if (!n_empty && out_ready) begin
            e = q_nd.pop_front();
            check("out_data_nd", 32'(out_data_n), 32'(e));
         end
         if (in_valid && !m_full) begin
            if (in_data[31:29] == 3'd0) q_main.push_back(word(in_data));
            else if (exp_drop < 65535) exp_drop++;
         end
         if (in_valid && !n_full) q_nd.push_back(word(in_data));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] f);
      in_data  = f;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && !(q_main.size() == 0 && q_nd.size() == 0); k++) step();
      check("drain", 32'(count), 32'(0));
   endtask

   initial begin
      bit done;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      repeat (2) step();
      reset = 1'b0;
      mon_en = 1'b1;
      check("rst_count", 32'(count), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_drop", 32'(drop_count), 32'(0));

      // Basic extract
      send(32'h1800_00A5);
      check("basic_valid", 32'(out_valid), 32'(1));
      check("basic_data", 32'(out_data), 32'h3A5);
      step();
      check("basic_empty", 32'(count), 32'(0));
      check("basic_valid_lo", 32'(out_valid), 32'(0));

      // Destination filter
      send(32'h2000_0011);
      check("filt_drop", 32'(drop_count), 32'(1));
      check("filt_no_out", 32'(out_valid), 32'(0));
      check("nofilt_data", 32'(out_data_n), 32'h011);
      send(32'h0800_0022);
      check("filt_pass_data", 32'(out_data), 32'h122);
      check("filt_drop_hold", 32'(drop_count), 32'(1));
      drain();

      // Fill and backpressure
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(32'(i));
      check("full_count", 32'(count), 32'(4));
      check("full_ready", 32'(in_ready), 32'(0));
      in_data = 32'h0000_0005; in_valid = 1'b1;
      repeat (3) step();
      check("full_hold", 32'(count), 32'(4));
      check("full_head", 32'(out_data), 32'h001);
      out_ready = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
      end
      step();
      in_valid = 1'b0;
      check("fifth_accept", 32'(done), 32'(1));
      drain();

      // Simultaneous push/pop at count 2, across pointer wrap
      out_ready = 1'b0;
      send(flit(0));
      send(flit(1));
      check("pp_start", 32'(count), 32'(2));
      out_ready = 1'b1;
      for (int i = 2; i < 12; i++) begin
         in_data = flit(i); in_valid = 1'b1;
         step();
         check("pp_count", 32'(count), 32'(2));
      end
      in_valid = 1'b0;
      drain();

      // Reset mid-operation
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(flit(i + 40));
      check("mid_count", 32'(count), 32'(3));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_count", 32'(count), 32'(0));
      check("mid_rst_valid", 32'(out_valid), 32'(0));
      check("mid_rst_ready", 32'(in_ready), 32'(1));
      check("mid_rst_drop", 32'(drop_count), 32'(0));
      out_ready = 1'b1;
      send(32'h0000_0055);
      check("post_rst_data", 32'(out_data), 32'h055);
      drain();

      // Drop counter saturation
      in_data = 32'h2000_0011; in_valid = 1'b1;
      repeat (65540) step();
      check("sat_drop", 32'(drop_count), 32'hFFFF);
      repeat (3) step();
      in_valid = 1'b0;
      check("sat_hold", 32'(drop_count), 32'hFFFF);
      send(32'h0000_0077);
      check("sat_pass_data", 32'(out_data), 32'h077);
      check("sat_pass_valid", 32'(out_valid), 32'(1));
      drain();

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/depac_sum_fifo.md
Name: depac_sum_fifo

Overview:
Clocked, parametrised successor to the single-flit sum depacketizer. Accepts flits from the NoC router port, checks the destination field and discards misrouted flits, counting each discard. Extracts a configurable data field and tag field and packs them as {tag, data}. Buffers the result in a DEPTH-entry FIFO ahead of the sum function unit, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, NoC flit width
DATA_W, 8, data field width
DATA_LSB, 0, data field LSB in flit
TAG_W, 2, tag field width
TAG_LSB, 27, tag field LSB in flit
DEST_W, 3, destination-ID field width
DEST_LSB, 29, destination-ID field LSB in flit
MY_ID, 0, this node's destination ID
CHECK_DEST, 1, 1 = enable destination filtering; 0 = accept every flit
DEPTH, 4, FIFO entries (power of two, >=2)
OUTPUTWIDTH, TAG_W+DATA_W, output word width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_data  in  WIDTH  flit from NoC
in_valid  in  1  flit present
in_ready  out  1  block can consume a flit this cycle
out_data  out  OUTPUTWIDTH  {tag, data} to function unit
out_valid  out  1  FIFO head valid
out_ready  in  1  function unit accepts head
count  out  $clog2(DEPTH)+1  FIFO occupancy
drop_count  out  16  misrouted-flit counter, saturating

Behaviour:
- Reset (reset=1 at posedge): rd_ptr, wr_ptr, count and drop_count all go to 0; out_valid=0; in_ready=1 after reset. out_data is don't-care while out_valid=0. Reset overrides any simultaneous push or pop, and discards any in-flight FIFO contents.
- in_ready = (count != DEPTH). It is combinational from registers only and never depends on in_data or out_ready.
- Accept: in_valid && in_ready at posedge.
- Match: CHECK_DEST==0, or in_data[DEST_LSB+:DEST_W]==MY_ID.
- Accept with match: push {in_data[TAG_LSB+:TAG_W], in_data[DATA_LSB+:DATA_W]} at wr_ptr; wr_ptr increments, wrapping DEPTH-1 to 0.
- Accept without match: no push; drop_count increments, saturating at 16'hFFFF. A drop still requires in_ready=1.
- Pop: out_valid && out_ready at posedge; rd_ptr increments with wrap.
- out_valid = (count != 0); out_data = mem[rd_ptr]. Both come from registers, with no combinational path from input to output.
- Latency: a flit accepted at edge N appears on out_data/out_valid after edge N if the FIFO was empty. First-word latency is 1 cycle; there is no fall-through.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Full (count==DEPTH): in_ready=0, no accept, and drop_count does not change. A pop in the same cycle does not enable a push in that cycle; in_ready rises the next cycle.
- Empty (count==0): out_valid=0. out_ready is ignored and no pop occurs.
- Ordering: strictly FIFO. Dropped flits leave no gap.
- Field rules: each field must fit inside WIDTH (DATA_LSB+DATA_W<=WIDTH, and likewise for tag and dest). Fields may overlap; the implementation does not check overlap. This is an elaboration-time assertion, not runtime logic.

Test Plan:
- Basic extract (defaults, out_ready=1): in_data=32'h1800_00A5 -> out_data=10'h3A5 one cycle later, out_valid for 1 cycle, count returns to 0.
- Dest filter: in_data=32'h2000_0011 (dest=1) -> no output, drop_count=1. Then 32'h0800_0022 -> out_data=10'h122, drop_count stays 1. With CHECK_DEST=0, the first flit gives out_data=10'h011.
- Fill/backpressure: out_ready=0, push 8'h01..8'h04 with tag 0 -> count=4, in_ready=0. A 5th flit held on in_valid is not accepted. Raise out_ready -> outputs 10'h001..10'h004 in order, then the 5th flit follows.
- Simultaneous push/pop at count=2 -> count stays 2 and data order is preserved across pointer wrap (push 10 flits through DEPTH=4).
- Reset mid-operation: count=3, assert reset one cycle -> count=0, out_valid=0, in_ready=1, drop_count=0. The next flit 32'h0000_0055 gives out_data=10'h055.
- Saturation: 65540 misrouted flits -> drop_count=16'hFFFF and holds there; a matching flit still passes.
